// File: rtl/commit_trace_queue_pkg.sv
// Shared types for the commit trace queue: the packed commit record and the helper
// that applies the x0 write filter before an entry is stored.
package commit_trace_queue_pkg;

    localparam int COMMIT_ENTRY_W = 230;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] pre_pc;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
    } commit_entry_t;

    // Writes to x0 are architecturally dead, so the checker sees wen=0 and data=0.
    function automatic commit_entry_t make_entry(
        input logic [63:0] pc,
        input logic [31:0] instr,
        input logic [63:0] pre_pc,
        input logic        reg_wen,
        input logic [4:0]  rd,
        input logic [63:0] wb_data
    );
        commit_entry_t e;
        e.pc     = pc;
        e.instr  = instr;
        e.pre_pc = pre_pc;
        e.wen    = reg_wen & (rd != 5'd0);
        e.rd     = rd;
        e.data   = e.wen ? wb_data : 64'd0;
        return e;
    endfunction

endpackage

// File: rtl/commit_trace_queue_sync_fifo.sv
// In-order FIFO with flop storage, wrapping pointers and an occupancy count.
// A push is accepted at full only when the head is popped in the same cycle.
module commit_trace_queue_sync_fifo #(
    parameter int WIDTH = 230,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_req,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop_req,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       push_ok,
    output logic [$clog2(DEPTH):0]     count_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop_req & ~empty;
    assign push_ok = push_req & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign count_next = count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the top masks the head while the queue is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/commit_trace_queue.sv
// Buffers per-cycle commit records after writeback and drains them in order to the
// trace checker; tracks retired count, drop overflow and pipeline back-pressure.
module commit_trace_queue
    import commit_trace_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_commit,
    input  logic [63:0] w_pc,
    input  logic [31:0] w_instr,
    input  logic [63:0] w_pre_pc,
    input  logic        w_reg_wen,
    input  logic [4:0]  w_rd,
    input  logic [63:0] w_wb_data,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [63:0] trace_pc,
    output logic [31:0] trace_instr,
    output logic [63:0] trace_pre_pc,
    output logic        trace_wen,
    output logic [4:0]  trace_rd,
    output logic [63:0] trace_data,
    output logic        commit_stall,
    output logic [63:0] instret,
    output logic        overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    commit_entry_t    push_entry;
    commit_entry_t    head_entry;
    logic             fifo_empty;
    logic             push_ok;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] free_d;

    logic        commit_stall_q, commit_stall_d;
    logic [63:0] instret_q, instret_d;
    logic        overflow_q, overflow_d;

    assign push_entry = make_entry(w_pc, w_instr, w_pre_pc, w_reg_wen, w_rd, w_wb_data);

    commit_trace_queue_sync_fifo #(
        .WIDTH (COMMIT_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_req   (w_commit),
        .wdata      (push_entry),
        .pop_req    (trace_valid & trace_ready),
        .rdata      (head_entry),
        .empty      (fifo_empty),
        .push_ok    (push_ok),
        .count_next (count_d)
    );

    assign trace_valid = ~fifo_empty;

    // Head fields read as zero whenever nothing is queued, including straight after reset.
    always_comb begin
        trace_pc     = 64'd0;
        trace_instr  = 32'd0;
        trace_pre_pc = 64'd0;
        trace_wen    = 1'b0;
        trace_rd     = 5'd0;
        trace_data   = 64'd0;
        if (trace_valid) begin
            trace_pc     = head_entry.pc;
            trace_instr  = head_entry.instr;
            trace_pre_pc = head_entry.pre_pc;
            trace_wen    = head_entry.wen;
            trace_rd     = head_entry.rd;
            trace_data   = head_entry.data;
        end
    end

    always_comb begin
        free_d         = CNT_W'(DEPTH) - count_d;
        commit_stall_d = (free_d <= CNT_W'(AFULL_LVL));
        instret_d      = instret_q + 64'(push_ok);
        overflow_d     = overflow_q | (w_commit & ~push_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_stall_q <= 1'b0;
            instret_q      <= 64'd0;
            overflow_q     <= 1'b0;
        end else begin
            commit_stall_q <= commit_stall_d;
            instret_q      <= instret_d;
            overflow_q     <= overflow_d;
        end
    end

    assign commit_stall = commit_stall_q;
    assign instret      = instret_q;
    assign overflow     = overflow_q;

endmodule
